// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock.
// Latency: N = WIDTH/DIGIT cycles from the accepting edge to the done_out pulse.
// Backpressure: none; start_in is honoured only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk_in        clock, rising edge
//   rst_n_in      synchronous active-low reset
//   start_in      request a new addition (accepted in IDLE or DONE)
//   a_in, b_in    WIDTH-bit operands, captured on the accepting edge
//   carry_in      carry-in, captured on the accepting edge
//   busy_out      high while the digit steps are running
//   done_out      one-cycle pulse; results are valid in this cycle
//   sum_out       last completed sum (modulo 2^WIDTH)
//   carry_out     last completed carry out of the MSB
//   overflow_out  last completed signed overflow flag
//
// Optional feature macro: DIGIT_SERIAL_ADDER_OVERFLOW_EN
//   defined   -> overflow_out = carry-into-MSB XOR carry-out-of-MSB, held like carry_out
//   undefined -> overflow_out tied to 0
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject illegal geometry at elaboration.
  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("digit_serial_adder: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last_step;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CW-1:0]    step_cnt;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] psum;
  logic             carry_next;

  // ---------------------------------------------------------------
  // Digit adder: one DIGIT-wide ripple slice fed by the carry register.
  // ---------------------------------------------------------------
  always_comb begin
    a_dig = a_sh[DIGIT-1:0];
    b_dig = b_sh[DIGIT-1:0];
    {carry_next, psum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    // Partial sum enters at the top; after N steps digit 0 has reached bit 0.
    res_next = (res_sh >> DIGIT) | (WIDTH'(psum) << (WIDTH - DIGIT));
  end

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = (step_cnt == CW'(N - 1));
    case (state)
      ST_IDLE: begin
        if (start_in) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // DONE accepts directly so back-to-back operation costs N+1 cycles.
        if (start_in) begin
          accept     = 1'b1;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy_out = (state == ST_RUN);
  assign done_out = (state == ST_DONE);

  // ---------------------------------------------------------------
  // Datapath: operand/result shift registers, carry, step counter,
  // and the result registers that only move on completion.
  // ---------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_q   <= 1'b0;
      step_cnt  <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sh     <= a_in;
      b_sh     <= b_in;
      res_sh   <= '0;
      carry_q  <= carry_in;
      step_cnt <= '0;
    end else if (state == ST_RUN) begin
      a_sh     <= a_sh >> DIGIT;
      b_sh     <= b_sh >> DIGIT;
      res_sh   <= res_next;
      carry_q  <= carry_next;
      step_cnt <= step_cnt + CW'(1);
      if (last_step) begin
        sum_out   <= res_next;
        carry_out <= carry_next;
      end
    end
  end

`ifdef DIGIT_SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q;
  logic carry_into_msb;

  // On the last step the operand MSBs sit at bit DIGIT-1 of the slice, so the
  // carry into the MSB is recovered from sum ^ a ^ b at that position.
  assign carry_into_msb = psum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      ovf_q <= 1'b0;
    end else if (!accept && state == ST_RUN && last_step) begin
      ovf_q <= carry_into_msb ^ carry_next;
    end
  end

  assign overflow_out = ovf_q;
`else
  assign overflow_out = 1'b0;
`endif

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, multi-cycle successor to the single-bit half adder. It adds two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock through a registered carry. Operation uses a start/busy/done handshake. It lets the datapath trade adder area for latency, and is the first adder in the lab library with sequential control.

## Interface
- WIDTH, default 8: operand and sum width in bits; must be ≥ 1.
- DIGIT, default 2: bits added per cycle; 1 ≤ DIGIT ≤ WIDTH, and WIDTH % DIGIT == 0. Any other setting is an elaboration error.
- clk_in  input  1  clock; all state changes on its rising edge.
- rst_n_in  input  1  reset; one clock; reset is synchronous and active-low.
- start_in  input  1  request to begin an addition; sampled only when the block can accept.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- carry_in  input  1  carry-in; captured on the accepting edge.
- busy_out  output  1  high while an addition is in progress (RUN state).
- done_out  output  1  one-cycle pulse; sum_out and carry_out are valid in this cycle.
- sum_out  output  WIDTH  result; holds the last completed sum.
- carry_out  output  1  carry out of the MSB; holds the last completed value.
- overflow_out  output  1  signed two's-complement overflow; see Configuration.

## Operation
- N = WIDTH/DIGIT digit steps per addition.
- FSM states:
  - IDLE: accepts start_in=1 and goes to RUN.
  - RUN: performs N digit steps; after step N goes to DONE.
  - DONE: lasts one cycle. Goes to RUN if start_in=1, otherwise to IDLE.
- Accept (IDLE or DONE with start_in=1):
  - latch a_in and b_in into shift registers;
  - load the carry register with carry_in;
  - clear the step counter.
- Each RUN edge:
  - add the low DIGIT bits of both shift registers plus the carry register;
  - the DIGIT-bit partial sum enters the top of the result shift register, which shifts right by DIGIT;
  - the new carry is registered;
  - the operand registers shift right by DIGIT.
- On step N:
  - copy the result register to sum_out and the final carry to carry_out;
  - assert done_out for the next cycle.
- sum_out and carry_out change only on a completion edge, or to 0 on reset. They hold stable through IDLE and through any later RUN.
- start_in during RUN is ignored; no queuing, no error flag.
- Inputs a_in, b_in and carry_in are don't-care except on the accepting edge.
- Arithmetic is modulo 2^WIDTH on sum_out; carry_out is bit WIDTH of a_in + b_in + carry_in.

## Timing
- Reset (rst_n_in=0 at an edge):
  - state goes to IDLE; busy_out=0, done_out=0, sum_out=0, carry_out=0, overflow_out=0;
  - internal shift registers, counter and carry are cleared;
  - reset takes priority over start_in.
- Reset during RUN aborts the addition: no done_out pulse, and outputs are cleared.
- Accept at edge E0:
  - busy_out=1 from E0 through E_N;
  - done_out=1 for exactly the cycle after E_N, and busy_out=0 in that cycle.
- Latency from accepting edge to done_out: N cycles. With DIGIT=WIDTH, done_out follows the accepting edge by one cycle.
- Back-to-back throughput: start_in held high gives one result every N+1 cycles, because DONE accepts directly.
- done_out is never asserted for two consecutive cycles.

## Configuration
- Macro DIGIT_SERIAL_ADDER_OVERFLOW_EN.
- Defined: overflow_out is set on completion to carry-into-MSB XOR carry-out-of-MSB, treating operands as signed. It is updated and held exactly like carry_out.
- Not defined: overflow_out is tied to 0, and no overflow logic is synthesised.
- The port list is identical in both cases.

## Test plan
All scenarios use WIDTH=8 and DIGIT=2 unless noted.
- 0xFF + 0x01, carry_in=0, start at E0:
  - busy_out high for 4 cycles;
  - done_out 4 cycles after E0 with sum_out=0x00, carry_out=1.
- 0x3C + 0x5A, carry_in=1: sum_out=0x97, carry_out=0.
- Hold outputs and ignore busy start:
  - apply start_in=1 with new operands during RUN step 2;
  - the first result completes unchanged, and no extra done_out follows;
  - sum_out stays at that result through 10 idle cycles.
- Reset mid-run: rst_n_in=0 after 2 RUN steps of 0xAA + 0x55 gives no done_out; all outputs 0; the next start completes normally.
- Back-to-back: start_in held high with 0x10 + 0x20, then 0x01 + 0x01 presented on the DONE cycle:
  - done_out pulses 5 cycles apart;
  - results are 0x30, then 0x02.
- Overflow and single-cycle mode:
  - 0x7F + 0x01 gives sum_out=0x80, carry_out=0; overflow_out=1 with the macro, 0 without;
  - repeat with DIGIT=8: done_out follows 1 cycle after the accepting edge.
